// File: rtl/gon_rr_gather.sv
// Gather network from a tag-matched PE array to the GLB: round-robin grant among
// eligible PEs, registered output FIFO carrying payload plus source index, sync flush.
module gon_rr_gather #(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 8,
    parameter int DATA_W     = 32,
    parameter int XID_W      = 5,
    parameter int YID_W      = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int N     = NUM_ROWS * NUM_COLS,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XID_W-1:0]    tag_x,
    input  logic [YID_W-1:0]    tag_y,
    input  logic                set_xid,
    input  logic [XID_W-1:0]    xid_scan_in,
    input  logic                set_yid,
    input  logic [YID_W-1:0]    yid_scan_in,
    input  logic                flush,
    input  logic [N-1:0]        pe_valid,
    output logic [N-1:0]        pe_ready,
    input  logic [N*DATA_W-1:0] pe_data,
    output logic                gon_valid,
    input  logic                gon_ready,
    output logic [DATA_W-1:0]   gon_data,
    output logic [IDX_W-1:0]    gon_src,
    output logic [CNT_W-1:0]    fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = IDX_W + DATA_W;

    logic [XID_W-1:0]  xid_q [N];
    logic [XID_W-1:0]  xid_d [N];
    logic [YID_W-1:0]  yid_q [NUM_ROWS];
    logic [YID_W-1:0]  yid_d [NUM_ROWS];
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] pe_data_arr [N];
    logic [N-1:0]      elig;
    logic              any_elig;
    logic [IDX_W-1:0]  grant;
    logic              full;
    logic              grant_ok;
    logic              push;
    logic              pop;

    for (genvar k = 0; k < N; k++) begin : g_pe
        assign pe_data_arr[k] = pe_data[k*DATA_W +: DATA_W];
        assign elig[k] = pe_valid[k] && (xid_q[k] == tag_x) && (yid_q[k/NUM_COLS] == tag_y);
    end

    // Circular search starting at rr_ptr; the first hit wins.
    always_comb begin
        logic [IDX_W:0] cand;
        cand     = '0;
        any_elig = 1'b0;
        grant    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
            if (!any_elig && elig[cand[IDX_W-1:0]]) begin
                any_elig = 1'b1;
                grant    = cand[IDX_W-1:0];
            end
        end
    end

    // Grant depends only on registered occupancy, never on gon_ready.
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign grant_ok = any_elig && !full && !flush && !rst;
    assign pe_ready = grant_ok ? (N'(1) << grant) : '0;
    assign push     = grant_ok && pe_valid[grant];
    assign pop      = (count_q != '0) && gon_ready;

    always_comb begin
        xid_d    = xid_q;
        yid_d    = yid_q;
        mem_d    = mem_q;
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (set_xid) begin
            xid_d[0] = xid_scan_in;
            for (int i = 1; i < N; i++) xid_d[i] = xid_q[i-1];
        end
        if (set_yid) begin
            yid_d[0] = yid_scan_in;
            for (int i = 1; i < NUM_ROWS; i++) yid_d[i] = yid_q[i-1];
        end
        if (flush) begin
            rr_ptr_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {grant, pe_data_arr[grant]};
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
                rr_ptr_d = (grant == IDX_W'(N-1)) ? '0 : grant + 1'b1;
            end
            if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) xid_q[i] <= '0;
            for (int i = 0; i < NUM_ROWS; i++) yid_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            xid_q    <= xid_d;
            yid_q    <= yid_d;
            mem_q    <= mem_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign gon_valid  = (count_q != '0);
    assign gon_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign gon_src    = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
    assign fifo_count = count_q;

endmodule

// File: tb/tb_gon_rr_gather.sv
// Scoreboard bench for gon_rr_gather: inputs change at the falling edge and
// outputs are checked shortly after, well away from the rising edge.
module tb_gon_rr_gather;

    localparam int NUM_ROWS   = 6;
    localparam int NUM_COLS   = 8;
    localparam int DATA_W     = 32;
    localparam int XID_W      = 5;
    localparam int YID_W      = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int N          = NUM_ROWS * NUM_COLS;
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W      = IDX_W + DATA_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [XID_W-1:0]    tag_x;
    logic [YID_W-1:0]    tag_y;
    logic                set_xid;
    logic [XID_W-1:0]    xid_scan_in;
    logic                set_yid;
    logic [YID_W-1:0]    yid_scan_in;
    logic                flush;
    logic [N-1:0]        pe_valid;
    logic [N-1:0]        pe_ready;
    logic [N*DATA_W-1:0] pe_data;
    logic                gon_valid;
    logic                gon_ready;
    logic [DATA_W-1:0]   gon_data;
    logic [IDX_W-1:0]    gon_src;
    logic [CNT_W-1:0]    fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_m    = 0;
    logic [ENT_W-1:0] sb[$];

    gon_rr_gather #(
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .DATA_W(DATA_W),
        .XID_W(XID_W), .YID_W(YID_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .tag_x(tag_x), .tag_y(tag_y),
        .set_xid(set_xid), .xid_scan_in(xid_scan_in),
        .set_yid(set_yid), .yid_scan_in(yid_scan_in),
        .flush(flush), .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
        .gon_valid(gon_valid), .gon_ready(gon_ready), .gon_data(gon_data),
        .gon_src(gon_src), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] data_of(int k);
        if (k == 5) return DATA_W'(32'hA5);
        return DATA_W'(32'hC0DE_0000 + k);
    endfunction

    function automatic logic [N-1:0] onehot(int k);
        logic [N-1:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [ENT_W-1:0] entry(int k);
        return {IDX_W'(k), data_of(k)};
    endfunction

    function automatic int model_grant(logic [N-1:0] el, int rr);
        for (int i = 0; i < N; i++) begin
            if (el[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; tag_x = '0; tag_y = '0; set_xid = 0; set_yid = 0;
        xid_scan_in = '0; yid_scan_in = '0; flush = 0; gon_ready = 0;
        pe_valid = '1;
        for (int k = 0; k < N; k++) pe_data[k*DATA_W +: DATA_W] = data_of(k);
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL reset_pe_ready: got %h exp 0", pe_ready); end
        n_tests++; if (gon_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gon_valid: got %b exp 0", gon_valid); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        n_tests++; if (gon_data !== '0 || gon_src !== '0) begin n_fail++; $display("FAIL reset_head: got %h/%0d exp 0/0", gon_data, gon_src); end
        pe_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        rr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_scan_match;
        for (int i = 0; i < N; i++) begin
            set_xid = 1'b1; xid_scan_in = XID_W'(N - 1 - i);
            set_yid = (i < NUM_ROWS); yid_scan_in = YID_W'(NUM_ROWS - i);
            @(negedge clk);
        end
        set_xid = 0; set_yid = 0;
        tag_x = XID_W'(5); tag_y = YID_W'(1); pe_valid = onehot(5); gon_ready = 0;
        #1;
        n_tests++; if (pe_ready !== onehot(5)) begin n_fail++; $display("FAIL scan_grant: got %h exp %h", pe_ready, onehot(5)); end
        n_tests++; if (gon_valid !== 1'b0) begin n_fail++; $display("FAIL scan_not_yet_valid: got %b exp 0", gon_valid); end
        sb.push_back(entry(5)); rr_m = 6;
        @(negedge clk);
        pe_valid = '0;
        #1;
        n_tests++; if (gon_valid !== 1'b1) begin n_fail++; $display("FAIL scan_valid: got %b exp 1", gon_valid); end
        n_tests++; if (gon_data !== DATA_W'(32'hA5) || gon_src !== IDX_W'(5)) begin
            n_fail++; $display("FAIL scan_head: got %h/%0d exp a5/5", gon_data, gon_src); end
        // row 4 holds XID 37, which aliases to 5 in 5 bits, but its YID is 5
        tag_y = YID_W'(5); pe_valid = onehot(37) | onehot(5);
        #1;
        n_tests++; if (pe_ready !== onehot(37)) begin n_fail++; $display("FAIL scan_alias: got %h exp %h", pe_ready, onehot(37)); end
        pe_valid = '0;
    endtask

    task automatic test_drain;
        pe_valid = '0; gon_ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < FIFO_DEPTH + 2; c++) begin
            #1;
            n_tests++; if (gon_valid !== (sb.size() != 0)) begin
                n_fail++; $display("FAIL drain_valid: got %b exp %b", gon_valid, sb.size() != 0); end
            if (gon_valid && sb.size() != 0) begin
                n_tests++; if ({gon_src, gon_data} !== sb[0]) begin
                    n_fail++; $display("FAIL drain_head: got %0d/%h exp %h", gon_src, gon_data, sb[0]); end
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        #1;
        n_tests++; if (fifo_count !== CNT_W'(sb.size())) begin n_fail++; $display("FAIL drain_count: got %0d exp %0d", fifo_count, sb.size()); end
        gon_ready = 1'b0;
    endtask

    task automatic test_round_robin;
        int g;
        logic [N-1:0] exp_r;
        flush = 1'b1; pe_valid = '0; gon_ready = 0;
        @(negedge clk);
        flush = 1'b0; sb.delete(); rr_m = 0;
        for (int i = 0; i < N; i++) begin
            set_xid = 1'b1; xid_scan_in = XID_W'(3);
            set_yid = (i < NUM_ROWS); yid_scan_in = YID_W'(1);
            @(negedge clk);
        end
        set_xid = 0; set_yid = 0;
        tag_x = XID_W'(3); tag_y = YID_W'(1); pe_valid = '1; gon_ready = 1'b1;
        for (int c = 0; c <= N; c++) begin
            #1;
            g = model_grant(pe_valid, rr_m);
            exp_r = (g >= 0 && sb.size() < FIFO_DEPTH) ? onehot(g) : '0;
            n_tests++; if (pe_ready !== exp_r) begin n_fail++; $display("FAIL rr_grant c=%0d: got %h exp %h", c, pe_ready, exp_r); end
            if (sb.size() != 0) begin
                n_tests++; if ({gon_src, gon_data} !== sb[0]) begin
                    n_fail++; $display("FAIL rr_head c=%0d: got %0d/%h exp %h", c, gon_src, gon_data, sb[0]); end
                void'(sb.pop_front());
            end
            if (exp_r != '0) begin
                sb.push_back(entry(g));
                rr_m = (g == N - 1) ? 0 : g + 1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_backpressure;
        flush = 1'b1; pe_valid = '0; gon_ready = 0;
        @(negedge clk);
        flush = 1'b0; sb.delete(); rr_m = 0;
        pe_valid = onehot(0) | onehot(1) | onehot(2);
        #1;
        n_tests++; if (pe_ready !== onehot(0)) begin n_fail++; $display("FAIL full_g0: got %h exp %h", pe_ready, onehot(0)); end
        sb.push_back(entry(0));
        @(negedge clk); #1;
        n_tests++; if (pe_ready !== onehot(1)) begin n_fail++; $display("FAIL full_g1: got %h exp %h", pe_ready, onehot(1)); end
        sb.push_back(entry(1));
        @(negedge clk); #1;
        n_tests++; if (fifo_count !== CNT_W'(2)) begin n_fail++; $display("FAIL full_count: got %0d exp 2", fifo_count); end
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL full_block: got %h exp 0", pe_ready); end
        @(negedge clk);
        gon_ready = 1'b1;
        #1;
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL full_block_pop: got %h exp 0", pe_ready); end
        n_tests++; if ({gon_src, gon_data} !== sb[0]) begin n_fail++; $display("FAIL full_head0: got %0d/%h exp %h", gon_src, gon_data, sb[0]); end
        void'(sb.pop_front());
        @(negedge clk); #1;
        n_tests++; if (fifo_count !== CNT_W'(1)) begin n_fail++; $display("FAIL full_count1: got %0d exp 1", fifo_count); end
        n_tests++; if (pe_ready !== onehot(2)) begin n_fail++; $display("FAIL full_g2: got %h exp %h", pe_ready, onehot(2)); end
        n_tests++; if ({gon_src, gon_data} !== sb[0]) begin n_fail++; $display("FAIL full_head1: got %0d/%h exp %h", gon_src, gon_data, sb[0]); end
        void'(sb.pop_front());
        sb.push_back(entry(2)); rr_m = 3;
        @(negedge clk);
    endtask

    task automatic test_flush;
        gon_ready = 0; pe_valid = onehot(0) | onehot(1);
        #1;
        n_tests++; if (pe_ready !== onehot(0)) begin n_fail++; $display("FAIL flush_fill0: got %h exp %h", pe_ready, onehot(0)); end
        @(negedge clk); #1;
        n_tests++; if (pe_ready !== onehot(1)) begin n_fail++; $display("FAIL flush_fill1: got %h exp %h", pe_ready, onehot(1)); end
        @(negedge clk);
        flush = 1'b1; gon_ready = 1'b1;
        #1;
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL flush_ready_full: got %h exp 0", pe_ready); end
        @(negedge clk);
        flush = 1'b0; gon_ready = 1'b0; pe_valid = onehot(1) | onehot(3);
        #1;
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", fifo_count); end
        n_tests++; if (gon_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", gon_valid); end
        n_tests++; if (pe_ready !== onehot(1)) begin n_fail++; $display("FAIL flush_rr_reset: got %h exp %h", pe_ready, onehot(1)); end
        sb.delete();
        @(negedge clk);
        flush = 1'b1; gon_ready = 1'b1;
        #1;
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL flush_ready_nonfull: got %h exp 0", pe_ready); end
        @(negedge clk);
        flush = 1'b0; gon_ready = 1'b0; pe_valid = '0;
        #1;
        n_tests++; if (fifo_count !== '0 || gon_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_pop_lost: got %0d/%b exp 0/0", fifo_count, gon_valid); end
        rr_m = 0;
    endtask

    task automatic test_tag_mismatch;
        tag_x = XID_W'(3); tag_y = YID_W'(9); pe_valid = '1; gon_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_tests++; if (pe_ready !== '0 || gon_valid !== 1'b0) begin
                n_fail++; $display("FAIL mismatch c=%0d: got %h/%b exp 0/0", c, pe_ready, gon_valid); end
            @(negedge clk);
        end
        pe_valid = '0;
    endtask

    task automatic test_async_reset;
        tag_x = XID_W'(3); tag_y = YID_W'(1); pe_valid = onehot(4); gon_ready = 1'b0;
        #1;
        n_tests++; if (pe_ready !== onehot(4)) begin n_fail++; $display("FAIL arst_pre_grant: got %h exp %h", pe_ready, onehot(4)); end
        @(negedge clk); #1;
        n_tests++; if (fifo_count !== CNT_W'(1) || pe_ready !== onehot(4)) begin
            n_fail++; $display("FAIL arst_pre_state: got %0d/%h exp 1/%h", fifo_count, pe_ready, onehot(4)); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (gon_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b exp 0", gon_valid); end
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL arst_ready: got %h exp 0", pe_ready); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL arst_count: got %0d exp 0", fifo_count); end
        @(negedge clk);
        rst = 1'b0; sb.delete(); rr_m = 0;
        pe_valid = onehot(7);
        #1;
        n_tests++; if (pe_ready !== '0) begin n_fail++; $display("FAIL arst_old_ids: got %h exp 0", pe_ready); end
        tag_x = '0; tag_y = '0;
        #1;
        n_tests++; if (pe_ready !== onehot(7)) begin n_fail++; $display("FAIL arst_zero_ids: got %h exp %h", pe_ready, onehot(7)); end
        pe_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan_match();
        test_drain();
        test_round_robin();
        test_drain();
        test_full_backpressure();
        test_drain();
        test_flush();
        test_tag_mismatch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
